// File: rtl/rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// rom_fetch_unit
// Read-side master for a synchronous instruction ROM. It drives the ROM
// address from the PC register and follows each read through a small
// latency tracker. Returned words go into an output FIFO, which presents them
// to the decode stage as a valid/ready stream of {pc, word}. A redirect loads
// a new PC and discards everything in flight and everything buffered.
// ---------------------------------------------------------------------------
module rom_fetch_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough to hold count + inflight without overflow.
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);

  // Reject parameter sets the credit scheme cannot support.
  generate
    if ((ROM_LATENCY < 1) || (ROM_LATENCY > 2)) begin : g_bad_latency
      $error("rom_fetch_unit: ROM_LATENCY must be 1 or 2");
    end
    if (FIFO_DEPTH < ROM_LATENCY + 2) begin : g_bad_depth
      $error("rom_fetch_unit: FIFO_DEPTH must be at least ROM_LATENCY+2");
    end
  endgenerate

  // Advance a FIFO pointer, wrapping at FIFO_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0]      r_pc;
  logic [ROM_LATENCY-1:0] r_trk_vld;                 // [0] = head, [ROM_LATENCY-1] = tail
  logic [ADDR_W-1:0]      r_trk_pc   [ROM_LATENCY];
  logic [ADDR_W-1:0]      r_fifo_pc  [FIFO_DEPTH];
  logic [DATA_W-1:0]      r_fifo_data[FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  logic [CNT_W-1:0]       w_inflight;
  logic                   w_credit_ok;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;

  // Count reads still travelling through the ROM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(ROM_LATENCY); i++) begin
      w_inflight = w_inflight + CNT_W'(r_trk_vld[i]);
    end
  end

  // Issue, capture and pop decisions. A redirect suppresses all three, and
  // the credit check deliberately ignores a same-cycle pop.
  always_comb begin
    w_credit_ok = ((r_count + w_inflight) < CNT_W'(FIFO_DEPTH));
    w_issue     = fetch_en & ~redirect_valid & w_credit_ok;
    w_push      = r_trk_vld[ROM_LATENCY-1] & ~redirect_valid;
    w_pop       = instr_valid & instr_ready & ~redirect_valid;
  end

  // PC register: redirect load, post-increment on issue (wraps silently), else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_issue) begin
      r_pc <= r_pc + ADDR_W'(1);
    end else begin
      r_pc <= r_pc;
    end
  end

  // Latency tracker: shifts every edge; the head records whether this edge
  // sampled a real read. A redirect kills every outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_vld <= '0;
      for (int i = 0; i < int'(ROM_LATENCY); i++) begin
        r_trk_pc[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_trk_vld <= '0;
    end else begin
      for (int i = int'(ROM_LATENCY) - 1; i > 0; i--) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
        r_trk_pc[i]  <= r_trk_pc[i-1];
      end
      r_trk_vld[0] <= w_issue;
      r_trk_pc[0]  <= r_pc;
    end
  end

  // FIFO storage: capture {tail pc, rom_q} when the tracker tail is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_trk_pc[ROM_LATENCY-1];
      r_fifo_data[r_wr_ptr] <= rom_q;
    end else begin
      r_fifo_pc[r_wr_ptr]   <= r_fifo_pc[r_wr_ptr];
      r_fifo_data[r_wr_ptr] <= r_fifo_data[r_wr_ptr];
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs come straight from registers; the head fields read as zero when empty.
  always_comb begin
    rom_address = r_pc;
    instr_valid = (r_count != CNT_W'(0));
    if (instr_valid) begin
      instr_data = r_fifo_data[r_rd_ptr];
      instr_pc   = r_fifo_pc[r_rd_ptr];
    end else begin
      instr_data = '0;
      instr_pc   = '0;
    end
  end

  rom_fetch_unit_chk #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_count (r_count)
  );

endmodule

// ---------------------------------------------------------------------------
// rom_fetch_unit_chk
// Simulation-only checks on the output buffer: the credit scheme must never
// let a captured word arrive at a full FIFO.
// ---------------------------------------------------------------------------
module rom_fetch_unit_chk #(
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [CNT_W-1:0] i_count
);

  // A capture into a full buffer would silently lose a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && (i_count == CNT_W'(FIFO_DEPTH))))
    else $error("rom_fetch_unit: capture into full output buffer");

  // Occupancy can never exceed the buffer size.
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (i_count <= CNT_W'(FIFO_DEPTH)))
    else $error("rom_fetch_unit: occupancy out of range");

endmodule

// File: tb/tb_rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_unit
// Bench for rom_fetch_unit with a 1-cycle ROM whose image is mem[i]=16'h1000+i.
// A queue-based model follows the fetch rules: outstanding reads with a due
// cycle, and a list of buffered {pc, word} entries. The model is compared with
// the DUT on every falling edge. Directed scenarios add literal expectations,
// and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_rom_fetch_unit;

  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] rom_address;
  logic [15:0] rom_q = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;

  int n_cmp = 0;
  int n_err = 0;

  rom_fetch_unit #(
    .ADDR_W(16), .DATA_W(16), .ROM_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_address    (rom_address),
    .rom_q          (rom_q),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_img(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  // Synchronous ROM: registered address, one-cycle read.
  always @(posedge clk) rom_q <= rom_img(rom_address);

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [15:0] pc; int due; } pend_t;
  typedef struct { logic [15:0] pc; logic [15:0] data; } ent_t;
  pend_t       m_pend[$];
  ent_t        m_fifo[$];
  logic [15:0] m_pc  = 16'h0000;
  int          m_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    bit   iss;
    ent_t e;
    pend_t p;
    if (!rst_n) begin
      m_pc = 16'h0000;
      m_pend.delete();
      m_fifo.delete();
    end else begin
      m_cyc++;
      if (redirect_valid) begin
        m_pc = redirect_pc;
        m_pend.delete();
        m_fifo.delete();
      end else begin
        iss = fetch_en && ((m_fifo.size() + m_pend.size()) < DEPTH);
        if (m_fifo.size() != 0 && instr_ready) void'(m_fifo.pop_front());
        while (m_pend.size() != 0 && m_pend[0].due == m_cyc) begin
          e.pc   = m_pend[0].pc;
          e.data = rom_img(m_pend[0].pc);
          m_fifo.push_back(e);
          void'(m_pend.pop_front());
        end
        if (iss) begin
          p.pc  = m_pc;
          p.due = m_cyc + LAT;
          m_pend.push_back(p);
          m_pc = m_pc + 16'h0001;
        end
      end
    end
  end

  // Compare DUT with model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cmp("rst_valid", {31'd0, instr_valid}, 32'd0);
      cmp("rst_data",  {16'd0, instr_data}, 32'd0);
      cmp("rst_pc",    {16'd0, instr_pc},   32'd0);
      cmp("rst_addr",  {16'd0, rom_address}, 32'd0);
    end else begin
      cmp("valid", {31'd0, instr_valid}, {31'd0, (m_fifo.size() != 0)});
      cmp("rom_address", {16'd0, rom_address}, {16'd0, m_pc});
      if (m_fifo.size() != 0) begin
        cmp("instr_pc",   {16'd0, instr_pc},   {16'd0, m_fifo[0].pc});
        cmp("instr_data", {16'd0, instr_data}, {16'd0, m_fifo[0].data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string nm, input logic [15:0] pc, input logic [15:0] d);
    cmp({nm, "_valid"}, {31'd0, instr_valid}, 32'd1);
    cmp({nm, "_pc"},    {16'd0, instr_pc},    {16'd0, pc});
    cmp({nm, "_data"},  {16'd0, instr_data},  {16'd0, d});
  endtask

  initial begin
    // 1. Reset release, continuous fetch and consume.
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (3) step();
    cmp("t1_rst_valid", {31'd0, instr_valid}, 32'd0);
    cmp("t1_rst_addr",  {16'd0, rom_address}, 32'd0);
    rst_n = 1'b1;
    step();
    cmp("t1_e1_valid", {31'd0, instr_valid}, 32'd0);
    cmp("t1_e1_addr",  {16'd0, rom_address}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_head("t1_stream", 16'(k), 16'h1000 + 16'(k));
    end

    // 2. Consumer stalls from reset: buffer fills and head holds.
    rst_n = 1'b0; instr_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (10) step();
    chk_head("t2_hold", 16'h0000, 16'h1000);
    cmp("t2_addr", {16'd0, rom_address}, 32'd4);
    instr_ready = 1'b1;
    for (int k = 1; k < 7; k++) begin
      step();
      chk_head("t2_resume", 16'(k), 16'h1000 + 16'(k));
    end

    // 3. Redirect while words are buffered.
    instr_ready = 1'b0;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    cmp("t3_flush_valid", {31'd0, instr_valid}, 32'd0);
    step();
    cmp("t3_gap_valid", {31'd0, instr_valid}, 32'd0);
    cmp("t3_gap_addr",  {16'd0, rom_address}, 32'h41);
    step(); chk_head("t3_w0", 16'h0040, 16'h1040);
    step(); chk_head("t3_w1", 16'h0041, 16'h1041);

    // 4. PC wrap through the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    step();
    step(); chk_head("t4_fffe", 16'hFFFE, 16'h0FFE);
    step(); chk_head("t4_ffff", 16'hFFFF, 16'h0FFF);
    step(); chk_head("t4_0000", 16'h0000, 16'h1000);
    step(); chk_head("t4_0001", 16'h0001, 16'h1001);

    // 5. Asynchronous reset with a non-empty buffer.
    instr_ready = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    cmp("t5_async_valid", {31'd0, instr_valid}, 32'd0);
    cmp("t5_async_data",  {16'd0, instr_data},  32'd0);
    cmp("t5_async_pc",    {16'd0, instr_pc},    32'd0);
    cmp("t5_async_addr",  {16'd0, rom_address}, 32'd0);
    step();
    rst_n = 1'b1; instr_ready = 1'b1;
    step();
    cmp("t5_e1_valid", {31'd0, instr_valid}, 32'd0);
    step(); chk_head("t5_restart", 16'h0000, 16'h1000);

    // 6. Redirect coinciding with a pop and a capture.
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    cmp("t6_flush_valid", {31'd0, instr_valid}, 32'd0);
    step();
    step(); chk_head("t6_first", 16'h0100, 16'h1100);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 9) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom_range(0, 65535));
      rst_n          = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1; redirect_valid = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
